dcache_sram_arbiter: RTL and testbench

//  Shares one 512x32 byte-enabled simple-dual-port data-cache SRAM (1-cycle read latency, no output reg)

---
 rtl/dcache_sram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dcache_sram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_sram_arbiter.sv
// Arbiter sharing one simple-dual-port D-cache data SRAM between CPU single-word
// accesses and line-engine fill/evict bursts, with same-line blocking and starvation limit.
module dcache_sram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4,
    parameter int LINE_WORDS = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [BE_WIDTH-1:0]   cpu_be,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ln_req,
    input  logic                  ln_we,
    input  logic [ADDR_WIDTH-1:0] ln_base,
    input  logic                  ln_wvalid,
    input  logic [DATA_WIDTH-1:0] ln_wdata,
    output logic                  ln_wready,
    output logic                  ln_rvalid,
    output logic [DATA_WIDTH-1:0] ln_rdata,
    output logic                  ln_done,
    output logic                  ln_busy,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [1:0]            state_dbg
);

    localparam int OFF = $clog2(LINE_WORDS);
    localparam int SW  = $clog2(STARVE_MAX + 1);
    localparam logic [OFF-1:0] LAST_BEAT  = OFF'(LINE_WORDS - 1);
    localparam logic [SW-1:0]  STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL       = 2'd1,
        EVICT      = 2'd2,
        EVICT_TAIL = 2'd3
    } state_t;

    state_t                     state, state_nxt;
    logic [OFF-1:0]             beat_cnt;
    logic [SW-1:0]              starve_cnt;
    logic [ADDR_WIDTH-OFF-1:0]  line_q;
    logic [ADDR_WIDTH-1:0]      line_addr;
    logic                       start_ln;
    logic                       cpu_same_line;
    logic                       fill_beat;
    logic                       last_beat;
    logic                       unused_ln_base;

    // Handshakes: cpu_gnt and fill beats (ln_wvalid && ln_wready) complete in the cycle
    // they are seen; cpu_rvalid/ln_rvalid qualify ram_rd_data one cycle after the read issue.
    assign start_ln      = (state == IDLE) && ln_req && (!cpu_req || starve_cnt == STARVE_LIM);
    assign cpu_same_line = (cpu_addr[ADDR_WIDTH-1:OFF] == line_q);
    assign fill_beat     = (state == FILL) && ln_wvalid;
    assign last_beat     = (beat_cnt == LAST_BEAT);
    assign line_addr     = {line_q, beat_cnt};
    assign unused_ln_base = ^ln_base[OFF-1:0];

    assign ln_busy   = (state != IDLE);
    assign state_dbg = state;
    assign cpu_rdata = rst ? '0 : ram_rd_data;
    assign ln_rdata  = rst ? '0 : ram_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_ln) state_nxt = ln_we ? FILL : EVICT;
            FILL:       if (fill_beat && last_beat) state_nxt = IDLE;
            EVICT:      if (last_beat) state_nxt = EVICT_TAIL;
            EVICT_TAIL: state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt        = 1'b0;
        ln_wready      = 1'b0;
        ram_wr_en      = 1'b0;
        ram_wr_addr    = '0;
        ram_wr_data    = '0;
        ram_wr_byte_en = '0;
        ram_rd_addr    = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!start_ln && cpu_req) begin
                        cpu_gnt = 1'b1;
                        if (cpu_we) begin
                            ram_wr_en      = 1'b1;
                            ram_wr_addr    = cpu_addr;
                            ram_wr_data    = cpu_wdata;
                            ram_wr_byte_en = cpu_be;
                        end else begin
                            ram_rd_addr = cpu_addr;
                        end
                    end
                end
                FILL: begin
                    ln_wready = 1'b1;
                    if (ln_wvalid) begin
                        ram_wr_en      = 1'b1;
                        ram_wr_addr    = line_addr;
                        ram_wr_data    = ln_wdata;
                        ram_wr_byte_en = '1;
                    end
                    // Read port is idle during a fill; lend it to CPU reads outside the line.
                    if (cpu_req && !cpu_we && !cpu_same_line) begin
                        cpu_gnt     = 1'b1;
                        ram_rd_addr = cpu_addr;
                    end
                end
                EVICT: begin
                    ram_rd_addr = line_addr;
                    if (cpu_req && cpu_we && !cpu_same_line) begin
                        cpu_gnt        = 1'b1;
                        ram_wr_en      = 1'b1;
                        ram_wr_addr    = cpu_addr;
                        ram_wr_data    = cpu_wdata;
                        ram_wr_byte_en = cpu_be;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            starve_cnt <= '0;
            line_q     <= '0;
            cpu_rvalid <= 1'b0;
            ln_rvalid  <= 1'b0;
            ln_done    <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            ln_rvalid  <= (state == EVICT);
            ln_done    <= (fill_beat && last_beat) || ((state == EVICT) && last_beat);
            case (state)
                IDLE: begin
                    if (start_ln) begin
                        line_q     <= ln_base[ADDR_WIDTH-1:OFF];
                        starve_cnt <= '0;
                        beat_cnt   <= '0;
                    end else if (cpu_req && ln_req && starve_cnt != STARVE_LIM) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                FILL:    if (ln_wvalid) beat_cnt <= beat_cnt + 1'b1;
                EVICT:   beat_cnt <= beat_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Bench for dcache_sram_arbiter: SRAM model, directed drivers, and a monitor that
// pops expected read data from queues whenever cpu_rvalid or ln_rvalid is seen.
module tb_dcache_sram_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk, rst, mem_clear;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [BW-1:0] cpu_be;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ln_req, ln_we;
    logic [AW-1:0] ln_base;
    logic          ln_wvalid;
    logic [DW-1:0] ln_wdata;
    logic          ln_wready, ln_rvalid, ln_done, ln_busy;
    logic [DW-1:0] ln_rdata;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data, ram_rd_data;
    logic [BW-1:0] ram_wr_byte_en;
    logic [1:0]    state_dbg;

    logic [DW-1:0] mem [512];
    logic [DW-1:0] cpu_exp_q[$];
    logic [DW-1:0] ln_exp_q[$];
    int n_cmp, n_bad, done_cnt;

    dcache_sram_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ln_req(ln_req), .ln_we(ln_we), .ln_base(ln_base), .ln_wvalid(ln_wvalid),
        .ln_wdata(ln_wdata), .ln_wready(ln_wready), .ln_rvalid(ln_rvalid), .ln_rdata(ln_rdata),
        .ln_done(ln_done), .ln_busy(ln_busy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish before 100000ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- SRAM model: byte-enabled write, 1-cycle read ----------------
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 512; i++) mem[i] <= '0;
        end else if (ram_wr_en) begin
            for (int b = 0; b < BW; b++)
                if (ram_wr_byte_en[b]) mem[ram_wr_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
        end
        ram_rd_data <= mem[ram_rd_addr];
    end

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk1("rvalid_exclusive", cpu_rvalid & ln_rvalid, 1'b0);
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cpu_rvalid_unexpected: got rvalid=1 expected no pending read");
                end else chk("cpu_rdata", cpu_rdata, cpu_exp_q.pop_front());
            end
            if (ln_rvalid) begin
                if (ln_exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ln_rvalid_unexpected: got rvalid=1 expected no pending beat");
                end else chk("ln_rdata", ln_rdata, ln_exp_q.pop_front());
            end
            if (ln_done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [BW-1:0] be, input logic exp_gnt, input logic [DW-1:0] exp_rdata);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
        @(negedge clk);
        chk1("cpu_gnt", cpu_gnt, exp_gnt);
        if (exp_gnt && we) begin
            chk1("cpu_ram_wr_en", ram_wr_en, 1'b1);
            chk("cpu_ram_wr_addr", 32'(ram_wr_addr), 32'(addr));
            chk("cpu_ram_wr_byte_en", 32'(ram_wr_byte_en), 32'(be));
        end
        if (exp_gnt && !we) begin
            chk("cpu_ram_rd_addr", 32'(ram_rd_addr), 32'(addr));
            cpu_exp_q.push_back(exp_rdata);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic fill_beats(input logic [AW-1:0] base, input logic [DW-1:0] d0, input bit probes);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 20) begin
            ln_wvalid = !(probes && cyc == 3);
            ln_wdata  = d0 + 32'(k);
            cpu_req   = 1'b0;
            if (probes && cyc == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h043; end
            if (probes && cyc == 5) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100; end
            @(negedge clk);
            chk1("fill_ln_wready", ln_wready, 1'b1);
            chk1("fill_ram_wr_en", ram_wr_en, ln_wvalid);
            if (ln_wvalid) begin
                chk("fill_wr_addr", 32'(ram_wr_addr), 32'({base[8:3], 3'(k)}));
                chk("fill_wr_data", ram_wr_data, d0 + 32'(k));
                chk("fill_wr_be", 32'(ram_wr_byte_en), 32'hF);
            end
            chk1("fill_ln_done_early", ln_done, 1'b0);
            if (probes && cyc == 1) chk1("fill_cpu_read_same_line_gnt", cpu_gnt, 1'b0);
            if (probes && cyc == 5) begin
                chk1("fill_cpu_read_other_gnt", cpu_gnt, 1'b1);
                cpu_exp_q.push_back(32'hCAFEF00D);
            end
            if (ln_wvalid) k++;
            cyc++;
            tick();
        end
        cpu_req = 1'b0; ln_wvalid = 1'b0; ln_req = 1'b0;
        @(negedge clk);
        chk1("fill_ln_done", ln_done, 1'b1);
        chk1("fill_end_busy", ln_busy, 1'b0);
        chk1("fill_end_wready", ln_wready, 1'b0);
        tick();
    endtask

    task automatic fill_line(input logic [AW-1:0] base, input logic [DW-1:0] d0, input bit probes);
        ln_req = 1'b1; ln_we = 1'b1; ln_base = base; cpu_req = 1'b0; ln_wvalid = 1'b0;
        @(negedge clk);
        chk1("fill_req_busy", ln_busy, 1'b0);
        chk1("fill_req_wready", ln_wready, 1'b0);
        tick();
        fill_beats(base, d0, probes);
    endtask

    task automatic evict_line(input logic [AW-1:0] base, input bit probes);
        ln_req = 1'b1; ln_we = 1'b0; ln_base = base; cpu_req = 1'b0;
        @(negedge clk);
        chk1("evict_req_busy", ln_busy, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            tick();
            ln_req  = (c < 9);
            cpu_req = 1'b0;
            if (probes && c == 2) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h041; cpu_wdata = 32'hBAD0BAD0; cpu_be = 4'hF;
            end
            if (probes && c == 3) begin
                cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h080; cpu_wdata = 32'h55AA55AA; cpu_be = 4'hF;
            end
            if (probes && c == 4) begin
                cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100;
            end
            @(negedge clk);
            chk1("evict_ln_rvalid", ln_rvalid, c >= 2);
            chk1("evict_ln_done", ln_done, c == 9);
            chk1("evict_busy", ln_busy, 1'b1);
            if (c <= 8) chk("evict_rd_addr", 32'(ram_rd_addr), 32'({base[8:3], 3'(c - 1)}));
            if (probes && c == 2) chk1("evict_cpu_write_same_line_gnt", cpu_gnt, 1'b0);
            if (probes && c == 3) begin
                chk1("evict_cpu_write_other_gnt", cpu_gnt, 1'b1);
                chk1("evict_cpu_wr_en", ram_wr_en, 1'b1);
                chk("evict_cpu_wr_addr", 32'(ram_wr_addr), 32'h080);
            end
            if (probes && c == 4) chk1("evict_cpu_read_gnt", cpu_gnt, 1'b0);
        end
        tick();
        cpu_req = 1'b0; ln_req = 1'b0;
        @(negedge clk);
        chk1("evict_end_busy", ln_busy, 1'b0);
        chk1("evict_end_rvalid", ln_rvalid, 1'b0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  gnts;
        bit  seen;
        n_cmp = 0; n_bad = 0; done_cnt = 0;
        rst = 1'b1; mem_clear = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = '1; cpu_be = 4'hF;
        ln_req = 1'b1; ln_we = 1'b1; ln_base = '0; ln_wvalid = 1'b1; ln_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_cpu_gnt", cpu_gnt, 1'b0);
        chk1("reset_ram_wr_en", ram_wr_en, 1'b0);
        chk1("reset_ln_busy", ln_busy, 1'b0);
        chk1("reset_ln_wready", ln_wready, 1'b0);
        chk1("reset_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("reset_ln_rvalid", ln_rvalid, 1'b0);
        chk1("reset_ln_done", ln_done, 1'b0);
        chk("reset_state", 32'(state_dbg), 32'h0);
        chk("reset_ram_rd_addr", 32'(ram_rd_addr), 32'h0);
        tick();
        rst = 1'b0; mem_clear = 1'b0; cpu_req = 1'b0; ln_req = 1'b0; ln_wvalid = 1'b0;
        tick();

        // Full-word write/read, then a single-byte write merges into the old word.
        cpu_access(1'b1, 9'h100, 32'hCAFEF00D, 4'hF, 1'b1, '0);
        cpu_access(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b1, '0);
        cpu_access(1'b0, 9'h010, '0, 4'h0, 1'b1, 32'hDEADBEEF);
        cpu_access(1'b1, 9'h010, 32'h11223344, 4'b0010, 1'b1, '0);
        cpu_access(1'b0, 9'h010, '0, 4'h0, 1'b1, 32'hDEAD33EF);

        // Fill 0x040 with a gap after beat 3 and CPU read probes.
        fill_line(9'h040, 32'h1, 1'b1);

        // Evict the same line (low base bits ignored) with CPU write probes.
        for (int k = 1; k <= 8; k++) ln_exp_q.push_back(32'(k));
        evict_line(9'h045, 1'b1);
        cpu_access(1'b0, 9'h041, '0, 4'h0, 1'b1, 32'h2);
        cpu_access(1'b0, 9'h080, '0, 4'h0, 1'b1, 32'h55AA55AA);

        // Starvation: CPU write held continuously while a fill is pending.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h020; cpu_wdata = 32'h12345678; cpu_be = 4'hF;
        ln_req = 1'b1; ln_we = 1'b1; ln_base = 9'h0C0;
        gnts = 0; seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (ln_busy) seen = 1'b1;
            else begin
                if (cpu_gnt) gnts++;
                tick();
            end
        end
        chk("starve_cpu_gnts", gnts, 4);
        chk1("starve_burst_started", seen, 1'b1);
        if (seen) chk1("starve_cpu_write_in_fill", cpu_gnt, 1'b0);
        tick();
        cpu_req = 1'b0;
        fill_beats(9'h0C0, 32'hC1, 1'b0);
        cpu_access(1'b0, 9'h020, '0, 4'h0, 1'b1, 32'h12345678);
        for (int k = 0; k < 8; k++) ln_exp_q.push_back(32'hC1 + 32'(k));
        evict_line(9'h0C0, 1'b0);

        // Reset after fill beat 3: abort, no ln_done, partial line kept.
        ln_req = 1'b1; ln_we = 1'b1; ln_base = 9'h180; cpu_req = 1'b0;
        @(negedge clk);
        tick();
        for (int k = 0; k < 3; k++) begin
            ln_wvalid = 1'b1; ln_wdata = 32'hB1 + 32'(k);
            @(negedge clk);
            chk("abort_fill_wr_addr", 32'(ram_wr_addr), 32'h180 + 32'(k));
            tick();
        end
        ln_wvalid = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h010; cpu_wdata = '0; cpu_be = 4'hF;
        rst = 1'b1;
        #1;
        chk1("rst_mid_ln_busy", ln_busy, 1'b0);
        chk1("rst_mid_ln_wready", ln_wready, 1'b0);
        chk1("rst_mid_ram_wr_en", ram_wr_en, 1'b0);
        chk1("rst_mid_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_mid_ln_done", ln_done, 1'b0);
        chk1("rst_mid_cpu_rvalid", cpu_rvalid, 1'b0);
        chk1("rst_mid_ln_rvalid", ln_rvalid, 1'b0);
        chk("rst_mid_state", 32'(state_dbg), 32'h0);
        @(negedge clk);
        tick();
        rst = 1'b0; cpu_req = 1'b0; ln_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk1("post_rst_ln_done", ln_done, 1'b0);
            tick();
        end
        ln_exp_q.push_back(32'hB1);
        ln_exp_q.push_back(32'hB2);
        ln_exp_q.push_back(32'hB3);
        for (int k = 0; k < 5; k++) ln_exp_q.push_back(32'h0);
        evict_line(9'h180, 1'b0);

        repeat (3) tick();
        chk("cpu_exp_q_drained", cpu_exp_q.size(), 0);
        chk("ln_exp_q_drained", ln_exp_q.size(), 0);
        chk("ln_done_count", done_cnt, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
